mem_arbiter: RTL and testbench

- Shares the single external memory port between the instruction cache (port "ic") and the data cache (port "dc").
- Each cache's mem_* interface connects to one requester port unchanged; the arbiter drives the real mem_* interface.
- One transaction is in flight at a time, because the memory returns untagged responses.
- Arbitration is round-robin, and a grant stays locked until the owner's transaction completes.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one untagged memory port between icache and dcache.
// A single transaction is in flight; the grant is held until it completes.
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int READ_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [1:0]             grant,
  output logic                   err
);

  localparam int MW = DATA_BITS / 8;
  localparam int CW = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(READ_BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RRESP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wdone_q, wdone_d;
  logic          err_q, err_d;

  logic own_ic, own_dc;
  logic in_req, in_wd, in_rr;
  logic o_valid, o_rw, o_dvalid;
  logic dphase, req_hs, dat_hs;
  logic win_dc;

  assign own_ic = grant_q[0];
  assign own_dc = grant_q[1];
  assign in_req = (state_q == REQ);
  assign in_wd  = (state_q == WDATA);
  assign in_rr  = (state_q == RRESP);

  assign o_valid  = (own_ic & ic_req_valid)
                  | (own_dc & dc_req_valid);
  assign o_rw     = (own_ic & ic_req_rw)
                  | (own_dc & dc_req_rw);
  assign o_dvalid = (own_ic & ic_req_data_valid)
                  | (own_dc & dc_req_data_valid);

  assign mem_req_addr = ({ADDR_BITS{own_ic}} & ic_req_addr)
                      | ({ADDR_BITS{own_dc}} & dc_req_addr);
  assign mem_req_rw   = o_rw;
  assign mem_req_data_bits =
      ({DATA_BITS{own_ic}} & ic_req_data_bits)
    | ({DATA_BITS{own_dc}} & dc_req_data_bits);
  assign mem_req_data_mask =
      ({MW{own_ic}} & ic_req_data_mask)
    | ({MW{own_dc}} & dc_req_data_mask);

  // Write data may go out while the request itself is still pending.
  assign dphase = in_wd | (in_req & o_rw & ~wdone_q);

  assign mem_req_valid      = in_req & o_valid;
  assign mem_req_data_valid = dphase & o_dvalid;
  assign req_hs = mem_req_valid & mem_req_ready;
  assign dat_hs = mem_req_data_valid & mem_req_data_ready;

  assign ic_req_ready      = own_ic & in_req & mem_req_ready;
  assign dc_req_ready      = own_dc & in_req & mem_req_ready;
  assign ic_req_data_ready = own_ic & dphase & mem_req_data_ready;
  assign dc_req_data_ready = own_dc & dphase & mem_req_data_ready;

  assign ic_resp_valid = own_ic & in_rr & mem_resp_valid;
  assign dc_resp_valid = own_dc & in_rr & mem_resp_valid;
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  assign grant = grant_q;
  assign err   = err_q;

  assign win_dc = dc_req_valid & (~ic_req_valid | ptr_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wdone_d = wdone_q;
    err_d   = err_q | (mem_resp_valid & ~in_rr);
    unique case (state_q)
      IDLE: begin
        wdone_d = 1'b0;
        if (ic_req_valid | dc_req_valid) begin
          grant_d = win_dc ? 2'b10 : 2'b01;
          ptr_d   = ~win_dc;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dat_hs) wdone_d = 1'b1;
        if (req_hs) begin
          if (!o_rw) begin
            state_d = RRESP;
            cnt_d   = '0;
          end else if (wdone_q | dat_hs) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        if (dat_hs) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      RRESP: begin
        if (mem_resp_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            grant_d = 2'b00;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      wdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wdone_q <= wdone_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = 16;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rv[2], rrw[2], dv[2];
  logic [AB-1:0] ra[2];
  logic [DB-1:0] wd[2];
  logic [MB-1:0] wm[2];
  logic          rrdy[2], drdy[2], rsv[2];
  logic [DB-1:0] rsd[2];

  logic          m_rqv, m_rw, m_dv;
  logic [AB-1:0] m_ra;
  logic [DB-1:0] m_d;
  logic [MB-1:0] m_m;
  logic          mrdy, mdrdy, mrv;
  logic [DB-1:0] mrd;
  logic [1:0]    grant;
  logic          err;

  mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_BEATS(RB)) dut (
    .clk(clk), .reset(rst_n),
    .ic_req_valid(rv[0]), .ic_req_ready(rrdy[0]),
    .ic_req_addr(ra[0]), .ic_req_rw(rrw[0]),
    .ic_req_data_valid(dv[0]), .ic_req_data_ready(drdy[0]),
    .ic_req_data_bits(wd[0]), .ic_req_data_mask(wm[0]),
    .ic_resp_valid(rsv[0]), .ic_resp_data(rsd[0]),
    .dc_req_valid(rv[1]), .dc_req_ready(rrdy[1]),
    .dc_req_addr(ra[1]), .dc_req_rw(rrw[1]),
    .dc_req_data_valid(dv[1]), .dc_req_data_ready(drdy[1]),
    .dc_req_data_bits(wd[1]), .dc_req_data_mask(wm[1]),
    .dc_resp_valid(rsv[1]), .dc_resp_data(rsd[1]),
    .mem_req_valid(m_rqv), .mem_req_ready(mrdy),
    .mem_req_addr(m_ra), .mem_req_rw(m_rw),
    .mem_req_data_valid(m_dv), .mem_req_data_ready(mdrdy),
    .mem_req_data_bits(m_d), .mem_req_data_mask(m_m),
    .mem_resp_valid(mrv), .mem_resp_data(mrd),
    .grant(grant), .err(err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model of the arbiter at transaction level
  int  m_own = -1;
  int  m_ptr = 1;
  bit  m_racc, m_dacc, m_err;
  int  m_nb;

  // handshakes seen at the last negedge, for the stimulus side
  bit  h_req[2], h_dat[2], h_rsp[2];
  bit  h_mrd, h_mrsp;
  int  n_rdy[2], n_drdy[2], n_rsp[2];
  logic [DB-1:0] cap_d;
  logic [MB-1:0] cap_m;
  logic [1:0] gq[$];
  logic [1:0] g_prev;

  always @(negedge clk) begin : mon
    int oi, w;
    bit e_mrv, e_dph, e_mdv, e_rd, e_rsv;
    logic [1:0] eg;
    logic [10:0] ectl, gctl;
    if (!rst_n) begin
      m_own = -1; m_ptr = 1;
      m_racc = 0; m_dacc = 0; m_nb = 0; m_err = 0;
      h_req = '{0, 0}; h_dat = '{0, 0}; h_rsp = '{0, 0};
      h_mrd = 0; h_mrsp = 0; g_prev = 0;
      chk("rst_out",
          {grant, m_rqv, rrdy[0], rrdy[1], m_dv, drdy[0],
           drdy[1], rsv[0], rsv[1], err, m_ra, m_rw, m_d, m_m},
          '0);
    end else begin
      oi = (m_own < 0) ? 0 : m_own;
      eg = (m_own < 0) ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01);
      e_mrv = (m_own >= 0) && !m_racc;
      e_dph = (m_own >= 0) && rrw[oi] && !m_dacc;
      e_mdv = e_dph && dv[oi];
      e_rd  = (m_own >= 0) && !rrw[oi] && m_racc;
      e_rsv = e_rd && mrv;
      ectl = {eg, e_mrv,
              m_own == 0 && e_mrv && mrdy,
              m_own == 1 && e_mrv && mrdy,
              e_mdv,
              m_own == 0 && e_dph && mdrdy,
              m_own == 1 && e_dph && mdrdy,
              m_own == 0 && e_rsv,
              m_own == 1 && e_rsv,
              m_err};
      gctl = {grant, m_rqv, rrdy[0], rrdy[1], m_dv, drdy[0],
              drdy[1], rsv[0], rsv[1], err};
      chk("ctl", gctl, ectl);
      if (e_mrv) chk("req", {m_ra, m_rw}, {ra[oi], rrw[oi]});
      if (e_mdv) chk("wdat", {m_d, m_m}, {wd[oi], wm[oi]});
      chk("rdata", {rsd[0], rsd[1]}, {mrd, mrd});
      for (int p = 0; p < 2; p++) begin
        h_req[p] = rv[p] & rrdy[p];
        h_dat[p] = dv[p] & drdy[p];
        h_rsp[p] = rsv[p];
        n_rdy[p] += int'(rrdy[p]);
        n_drdy[p] += int'(drdy[p]);
        n_rsp[p] += int'(rsv[p]);
      end
      h_mrd = m_rqv & mrdy & !m_rw;
      h_mrsp = mrv;
      if (m_dv && mdrdy) begin
        cap_d = m_d;
        cap_m = m_m;
      end
      if (grant != 0 && g_prev == 0) gq.push_back(grant);
      g_prev = grant;
      m_err = m_err | (mrv && !e_rd);
      if (m_own >= 0) begin
        if (e_mrv && mrdy) m_racc = 1;
        if (e_mdv && mdrdy) m_dacc = 1;
        if (e_rsv) m_nb++;
        if (rrw[oi] ? (m_racc && m_dacc) : (m_nb == RB)) begin
          m_own = -1;
          m_racc = 0; m_dacc = 0; m_nb = 0;
        end
      end else if (rv[0] || rv[1]) begin
        w = (rv[1] && (!rv[0] || m_ptr == 1)) ? 1 : 0;
        m_own = w;
        m_ptr = 1 - w;
      end
    end
  end

  // requester and memory agents
  bit busy[2], sr[2], sd[2];
  int sn[2];
  bit auto_mem = 0;
  bit auto_req = 0;
  int pend = 0;

  task automatic start(input int p, input logic [AB-1:0] a,
                       input logic w, input logic [DB-1:0] d,
                       input logic [MB-1:0] m, input logic dvi);
    busy[p] = 1; sr[p] = 0; sd[p] = 0; sn[p] = 0;
    rv[p] = 1; ra[p] = a; rrw[p] = w;
    wd[p] = d; wm[p] = m; dv[p] = w & dvi;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (h_req[p]) rv[p] = 0;
      if (h_dat[p]) dv[p] = 0;
      if (busy[p]) begin
        if (h_req[p]) sr[p] = 1;
        if (h_dat[p]) sd[p] = 1;
        if (h_rsp[p]) sn[p]++;
        if (rrw[p] ? (sr[p] && sd[p]) : (sn[p] == RB)) busy[p] = 0;
      end
    end
    if (auto_mem) begin
      if (h_mrd) pend += RB;
      if (h_mrsp && pend > 0) pend--;
      mrdy = ($urandom % 3) != 0;
      mdrdy = ($urandom % 3) != 0;
      mrv = (pend > 0) && (($urandom % 4) != 0);
      mrd = {$urandom, $urandom, $urandom, $urandom};
    end
    if (auto_req) begin
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && ($urandom % 4) == 0)
          start(p, AB'($urandom), 1'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                MB'($urandom), 1'($urandom));
        else if (busy[p] && rrw[p] && !sd[p] && !dv[p]
                 && ($urandom % 2) == 1)
          dv[p] = 1;
      end
    end
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int k = 0;
    while ((busy[0] || busy[1]) && k < lim) begin
      cyc();
      k++;
    end
    chk(tag, {busy[0], busy[1]}, 2'b00);
  endtask

  task automatic clr_cnt();
    n_rdy = '{0, 0}; n_drdy = '{0, 0}; n_rsp = '{0, 0};
    gq.delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    auto_mem = 0; auto_req = 0; pend = 0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 0; rrw[p] = 0; dv[p] = 0; ra[p] = '0;
      wd[p] = '0; wm[p] = '0; busy[p] = 0;
    end
    mrdy = 0; mdrdy = 0; mrv = 0; mrd = '0;
    repeat (3) cyc();
    rst_n = 1;
    clr_cnt();
  endtask

  initial begin
    int ns[2];
    do_reset();

    // ic read, beats 1..4
    start(0, 28'h0000123, 0, '0, '0, 0);
    cyc();
    mrdy = 1;
    cyc();
    mrdy = 0;
    for (int i = 1; i <= 4; i++) begin
      mrv = 1;
      mrd = DB'(i);
      cyc();
    end
    mrv = 0;
    cyc();
    chk("t1_ic_beats", n_rsp[0], 4);
    chk("t1_dc_beats", n_rsp[1], 0);
    chk("t1_grant", grant, 2'b00);
    chk("t1_gq", gq.size() == 1 ? gq[0] : 2'b11, 2'b01);

    // contention: back-to-back simultaneous writers alternate
    do_reset();
    mrdy = 1;
    mdrdy = 1;
    ns = '{0, 0};
    for (int k = 0; k < 80; k++) begin
      if (ns[0] >= 3 && ns[1] >= 3 && !busy[0] && !busy[1]) break;
      for (int p = 0; p < 2; p++)
        if (!busy[p] && ns[p] < 3) begin
          start(p, AB'(k), 1, DB'(k), '1, 1);
          ns[p]++;
        end
      cyc();
    end
    chk("t2_ngrant", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_g%0d", i),
          i < gq.size() ? gq[i] : 2'b11,
          (i % 2 == 0) ? 2'b10 : 2'b01);

    // dc write with fixed memory timing
    do_reset();
    start(1, 28'h0ABCDEF, 1,
          128'hDEADBEEF_00000000_CAFEF00D_12345678, 16'hFFFF, 1);
    repeat (3) cyc();
    mrdy = 1;
    cyc();
    mrdy = 0;
    cyc();
    mdrdy = 1;
    cyc();
    mdrdy = 0;
    chk("t3_idle", grant, 2'b00);
    chk("t3_rdy", n_rdy[1], 1);
    chk("t3_drdy", n_drdy[1], 1);
    chk("t3_resp", n_rsp[0] + n_rsp[1], 0);
    chk("t3_bits", cap_d, 128'hDEADBEEF_00000000_CAFEF00D_12345678);
    chk("t3_mask", cap_m, 16'hFFFF);

    // backpressure keeps ic's grant while dc waits
    do_reset();
    start(0, 28'h0000456, 0, '0, '0, 0);
    cyc();
    cyc();
    start(1, 28'h0000789, 0, '0, '0, 0);
    repeat (8) cyc();
    chk("t4_grant", grant, 2'b01);
    chk("t4_dcrdy", n_rdy[1], 0);
    auto_mem = 1;
    wait_idle(300, "t4_done");
    chk("t4_ngrant", gq.size(), 2);
    chk("t4_order", gq.size() == 2 ? {gq[0], gq[1]} : 4'hF, 4'b0110);
    chk("t4_beats", {8'(n_rsp[0]), 8'(n_rsp[1])}, {8'd4, 8'd4});

    // stray response while idle
    do_reset();
    mrv = 1;
    mrd = {4{32'h5A5A5A5A}};
    cyc();
    mrv = 0;
    cyc();
    chk("t5_err", err, 1);
    chk("t5_noresp", n_rsp[0] + n_rsp[1], 0);
    auto_mem = 1;
    start(0, 28'h0000AAA, 0, '0, '0, 0);
    wait_idle(300, "t5_rd");
    start(1, 28'h0000BBB, 1, DB'(7), 16'h00F0, 1);
    wait_idle(300, "t5_wr");
    chk("t5_sticky", err, 1);
    do_reset();
    chk("t5_clear", err, 0);

    // reset in the middle of a read
    start(0, 28'h0000CCC, 0, '0, '0, 0);
    cyc();
    mrdy = 1;
    cyc();
    mrdy = 0;
    mrv = 1;
    mrd = DB'(9);
    cyc();
    cyc();
    mrv = 0;
    rst_n = 0;
    #2;
    chk("t6_async", {grant, m_rqv, rrdy[0], rsv[0], err}, '0);
    do_reset();
    auto_mem = 1;
    start(1, 28'h0000DDD, 0, '0, '0, 0);
    wait_idle(300, "t6_rd");
    chk("t6_beats", n_rsp[1], 4);
    chk("t6_err", err, 0);

    // random traffic
    do_reset();
    auto_mem = 1;
    auto_req = 1;
    repeat (4000) cyc();
    auto_req = 0;
    wait_idle(500, "rnd_drain");
    chk("rnd_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
